// File: rtl/arith_pkg.sv
// arith_pkg: opcode type and encodings shared by the arithmetic pipeline.
package arith_pkg;
    typedef logic [1:0] op_t;
    localparam op_t OP_ADD  = 2'd0;
    localparam op_t OP_SUB  = 2'd1;
    localparam op_t OP_HALF = 2'd2;
    localparam op_t OP_POLY = 2'd3;
endpackage

// File: rtl/arith_sat.sv
// arith_sat: reduce a full-width natural result to OW bits by wrapping or clamping, flagging overflow.
module arith_sat #(
    parameter int FW  = 18,
    parameter int OW  = 17,
    parameter int SAT = 0
) (
    input  logic [FW-1:0] nat,
    input  logic          neg,
    output logic [OW-1:0] res,
    output logic          ovf
);
    localparam int XW = OW > FW ? OW : FW;
    logic [XW-1:0] ext;
    logic          big;
    always_comb begin
        // Negative differences are sign-extended so wrap mode yields the two's-complement value mod 2^OW.
        ext = neg ? ~XW'(~nat) : XW'(nat);
        big = ext > XW'({OW{1'b1}});
        ovf = neg || big;
        res = (neg && SAT != 0) ? '0 : (big && SAT != 0) ? '1 : ext[OW-1:0];
    end
endmodule

// File: rtl/arith_pipe_unit.sv
// arith_pipe_unit: two-stage valid/ready unsigned ADD/SUB/HALF/POLY unit with wrap or saturate output.
module arith_pipe_unit
    import arith_pkg::*;
#(
    parameter int W     = 8,
    parameter int OW    = 2*W+1,
    parameter int SAT   = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] res_cnt
);
    localparam int FW = 2*W+2;
    logic           s1_v;
    op_t            s1_op;
    logic [W-1:0]   s1_a, s1_b, s1_half;
    logic [2*W-1:0] s1_sq;
    logic           s2_go, neg, ovf;
    logic [FW-1:0]  a_f, b_f, nat;
    logic [OW-1:0]  res;

    // S2 may load whenever it is empty or its result leaves this cycle.
    assign s2_go    = !out_valid || out_ready;
    assign in_ready = !rst && (!s1_v || s2_go);

    always_comb begin
        a_f = FW'(s1_a);
        b_f = FW'(s1_b);
        nat = s1_op == OP_ADD  ? a_f + b_f :
              s1_op == OP_SUB  ? b_f - a_f :
              s1_op == OP_HALF ? FW'(s1_half) :
                                 FW'(s1_half) + a_f + FW'(s1_sq);
        neg = s1_op == OP_SUB && s1_b < s1_a;
    end

    arith_sat #(.FW(FW), .OW(OW), .SAT(SAT)) u_sat (
        .nat (nat),
        .neg (neg),
        .res (res),
        .ovf (ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_op   <= OP_ADD;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_half <= '0;
            s1_sq   <= '0;
        end else if (in_ready) begin
            s1_v    <= in_valid;
            s1_op   <= in_op;
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_half <= in_a >> 1;
            s1_sq   <= (2*W)'(in_a) * (2*W)'(in_a);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (s2_go) begin
            out_valid <= s1_v;
            if (s1_v) begin
                out_data <= res;
                out_ovf  <= ovf;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) res_cnt <= '0;
        else if (out_valid && out_ready) res_cnt <= res_cnt + 1'b1;
    end
endmodule

// File: tb/tb_arith_pipe_unit.sv
// tb_arith_pipe_unit: scoreboard bench driving three configurations of the unit with shared stimulus.
module tb_arith_pipe_unit;
    import arith_pkg::*;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    op_t         in_op = OP_ADD;
    logic [7:0]  in_a = '0, in_b = '0;
    logic        ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
    logic [16:0] od0, od2;
    logic [7:0]  od1;
    logic [15:0] rc0, rc1, base16;
    logic [1:0]  rc2;
    logic [32:0] q0[$], q1[$], q2[$];
    int          checks = 0, failures = 0, acc_n = 0, base_acc;
    logic [16:0] held;
    bit          done;
    int          wrap_exp[5] = '{1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    arith_pipe_unit #(.W(8), .OW(17), .SAT(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_op(in_op), .in_a(in_a),
        .in_b(in_b), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ovf(of0), .res_cnt(rc0));
    arith_pipe_unit #(.W(8), .OW(8), .SAT(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_op(in_op), .in_a(in_a),
        .in_b(in_b), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ovf(of1), .res_cnt(rc1));
    arith_pipe_unit #(.W(8), .OW(17), .SAT(0), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_op(in_op), .in_a(in_a),
        .in_b(in_b), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_ovf(of2), .res_cnt(rc2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference arithmetic on 64-bit signed integers; returns {ovf, data}.
    function automatic logic [32:0] model(input op_t op, input logic [7:0] a, input logic [7:0] b,
                                          input int ow, input bit sat);
        longint x, m, la, lb;
        la = longint'(a);
        lb = longint'(b);
        m  = (longint'(1) << ow) - 1;
        case (op)
            OP_ADD:  x = la + lb;
            OP_SUB:  x = lb - la;
            OP_HALF: x = la / 2;
            default: x = la / 2 + la + la * la;
        endcase
        if (x < 0) return {1'b1, sat ? 32'd0 : 32'(x & m)};
        if (x > m) return {1'b1, 32'(sat ? m : (x & m))};
        return {1'b0, 32'(x)};
    endfunction

    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst) begin
            if (in_valid && ir0) begin
                q0.push_back(model(in_op, in_a, in_b, 17, 1'b0));
                q1.push_back(model(in_op, in_a, in_b, 8, 1'b1));
                q2.push_back(model(in_op, in_a, in_b, 17, 1'b0));
                acc_n++;
            end
            if (ov0 && out_ready) begin
                if (q0.size() == 0) check("u0_extra", 1, 0);
                else begin
                    e = q0.pop_front();
                    check("u0_data", od0, e[31:0]);
                    check("u0_ovf", of0, e[32]);
                end
            end
            if (ov1 && out_ready) begin
                if (q1.size() == 0) check("u1_extra", 1, 0);
                else begin
                    e = q1.pop_front();
                    check("u1_data", od1, e[31:0]);
                    check("u1_ovf", of1, e[32]);
                end
            end
            if (ov2 && out_ready) begin
                if (q2.size() == 0) check("u2_extra", 1, 0);
                else begin
                    e = q2.pop_front();
                    check("u2_data", od2, e[31:0]);
                    check("u2_ovf", of2, e[32]);
                end
            end
        end
    end

    // Holds the transaction on the inputs until it is accepted; leaves in_valid high for back-to-back use.
    task automatic send(input op_t op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        in_op = op;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!ir0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q0.size() + q1.size() + q2.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", q0.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", ov0, 0);
        check("rst_data", od0, 0);
        check("rst_ovf", of0, 0);
        check("rst_cnt", rc0, 0);
        check("rst_ready", ir0, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", ir0, 1);

        @(posedge clk);
        #1;
        send(OP_ADD, 8'd15, 8'd15);
        in_valid = 1'b0;
        check("lat_early", ov0, 0);
        @(posedge clk);
        #1;
        check("lat_valid", ov0, 1);
        check("lat_data", od0, 30);
        drain();

        send(OP_POLY, 8'd255, 8'd0);
        send(OP_HALF, 8'd7, 8'd0);
        send(OP_SUB, 8'd5, 8'd3);
        send(OP_ADD, 8'd200, 8'd100);
        send(OP_SUB, 8'd3, 8'd5);
        send(OP_HALF, 8'd0, 8'd9);
        in_valid = 1'b0;
        drain();

        base_acc = acc_n;
        base16 = rc0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(OP_ADD, 8'(10 * i + 1), 8'd3);
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #2;
                check("bp_ready_low", ir0, 0);
                check("bp_accepted", acc_n - base_acc, 2);
                held = od0;
                repeat (2) begin
                    @(posedge clk);
                    #2;
                    check("bp_hold_data", od0, held);
                    check("bp_hold_valid", ov0, 1);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_res_cnt", 16'(rc0 - base16), 4);

        out_ready = 1'b0;
        send(OP_ADD, 8'd1, 8'd2);
        send(OP_ADD, 8'd3, 8'd4);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", ov0, 0);
        check("mid_rst_ready", ir0, 0);
        check("mid_rst_cnt", rc0, 0);
        check("mid_rst_data", od0, 0);
        q0.delete();
        q1.delete();
        q2.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_ready_after", ir0, 1);
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("mid_rst_quiet", ov0, 0);

        for (int i = 0; i < 5; i++) begin
            send(OP_HALF, 8'(i), 8'd0);
            in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("wrap_cnt", rc2, wrap_exp[i]);
        end
        drain();

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send(op_t'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("final_empty", q0.size() + q1.size() + q2.size(), 0);
        check("final_idle", ov0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
